byte_dispenser: RTL and testbench

Serializes up to three captured bytes onto a byte-wide put stream, one byte per transfer, in index order. It is the transmit end of the put/value stream the accumulator consumes. A load captures three bytes plus per-byte valid flags, and the block replays only the valid bytes with `putFlag` high. It then drops `putFlag` for a gap so the downstream accumulator publishes its registers. A `ready` input lets the consumer stall the stream.

---
 rtl/byte_dispenser_if.sv | 28 ++
 rtl/byte_dispenser.sv | 130 +++++++++++++
 tb/tb_byte_dispenser.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_dispenser_if.sv
// Load/stream bundle between a byte producer and the byte_dispenser.
// The master side issues loads and accepts the stream; the slave side is the dispenser.
interface byte_dispenser_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             d0_valid;
    logic             d1_valid;
    logic             d2_valid;
    logic             ready;
    logic [WIDTH-1:0] value;
    logic             putFlag;
    logic             busy;
    logic             done;

    modport master (
        output load, d0, d1, d2, d0_valid, d1_valid, d2_valid, ready,
        input  value, putFlag, busy, done
    );

    modport slave (
        input  load, d0, d1, d2, d0_valid, d1_valid, d2_valid, ready,
        output value, putFlag, busy, done
    );
endinterface

// File: rtl/byte_dispenser.sv
// Replays up to three captured bytes, valid ones only, onto a put/value stream,
// then holds putFlag low for MIN_GAP cycles so the consumer can publish.
module byte_dispenser #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MIN_GAP = 1
) (
    input logic             clk,
    input logic             reset_n,
    byte_dispenser_if.slave bus
);
    localparam int unsigned NB = 3;
    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                     state_q, state_n;
    logic [NB-1:0][WIDTH-1:0]   cap_q, cap_n;
    logic [NB-1:0]              pend_q, pend_n;
    logic [GW-1:0]              gap_q, gap_n;
    logic [WIDTH-1:0]           value_q, value_n;
    logic                       put_q, put_n;
    logic                       busy_q, busy_n;
    logic                       done_q, done_n;

    logic [NB-1:0][WIDTH-1:0]   din_c;
    logic [NB-1:0]              vin_c;
    logic [NB-1:0]              src_mask_c;
    logic [NB-1:0][WIDTH-1:0]   src_data_c;
    logic [NB-1:0]              first_c;
    logic [WIDTH-1:0]           first_data_c;

    assign din_c = {bus.d2, bus.d1, bus.d0};
    assign vin_c = {bus.d2_valid, bus.d1_valid, bus.d0_valid};

    // Lowest pending byte: taken from the inputs at load, from the capture afterwards
    always_comb begin
        src_mask_c   = (state_q == IDLE) ? vin_c : pend_q;
        src_data_c   = (state_q == IDLE) ? din_c : cap_q;
        first_c      = src_mask_c & (~src_mask_c + NB'(1));
        first_data_c = '0;
        for (int i = 0; i < NB; i++) begin
            if (first_c[i]) begin
                first_data_c = src_data_c[i];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        cap_n   = cap_q;
        pend_n  = pend_q;
        gap_n   = gap_q;
        value_n = value_q;
        put_n   = put_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    cap_n  = din_c;
                    busy_n = 1'b1;
                    if (vin_c == '0) begin
                        pend_n  = '0;
                        state_n = GAP;
                        done_n  = 1'b1;
                        gap_n   = GW'(MIN_GAP - 1);
                    end else begin
                        state_n = SEND;
                        pend_n  = vin_c & ~first_c;
                        value_n = first_data_c;
                        put_n   = 1'b1;
                    end
                end
            end
            SEND: begin
                // pend_q holds bytes still to offer after the one on value
                if (bus.ready) begin
                    if (pend_q != '0) begin
                        pend_n  = pend_q & ~first_c;
                        value_n = first_data_c;
                    end else begin
                        state_n = GAP;
                        put_n   = 1'b0;
                        value_n = '0;
                        done_n  = 1'b1;
                        gap_n   = GW'(MIN_GAP - 1);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gap_n = gap_q - GW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cap_q   <= '0;
            pend_q  <= '0;
            gap_q   <= '0;
            value_q <= '0;
            put_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cap_q   <= cap_n;
            pend_q  <= pend_n;
            gap_q   <= gap_n;
            value_q <= value_n;
            put_q   <= put_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign bus.value   = value_q;
    assign bus.putFlag = put_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_byte_dispenser.sv
// Scoreboard bench for byte_dispenser: loads push expected bytes and done markers,
// a negedge monitor pops them as transfers and done pulses appear.
module tb_byte_dispenser;
    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MIN_GAP = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    byte_dispenser_if #(.WIDTH(WIDTH)) bus ();

    byte_dispenser #(.WIDTH(WIDTH), .MIN_GAP(MIN_GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic       is_done;
        logic [7:0] b;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_cmp     = 0;
    int         n_mis     = 0;
    int         busy_run  = 0;
    int         last_busy = 0;
    logic       stalled   = 1'b0;
    logic [7:0] held      = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard on every transfer and done pulse
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_run = 0;
            stalled  = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_put_hold", 32'(bus.putFlag), 32'd1);
                chk("stall_value_hold", 32'(bus.value), 32'(held));
            end
            if (bus.putFlag && bus.ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_transfer");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("seq_byte_expected", 32'(mon_e.is_done), 32'd0);
                    chk("put_value", 32'(bus.value), 32'(mon_e.b));
                end
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("seq_done_expected", 32'(mon_e.is_done), 32'd1);
                    chk("done_put_low", 32'(bus.putFlag), 32'd0);
                    chk("done_value_zero", 32'(bus.value), 32'd0);
                end
            end
            stalled = bus.putFlag && !bus.ready;
            held    = bus.value;
            if (bus.busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy = busy_run;
                busy_run  = 0;
            end
        end
    end

    task automatic scramble();
        bus.d0       = 8'($urandom);
        bus.d1       = 8'($urandom);
        bus.d2       = 8'($urandom);
        bus.d0_valid = 1'($urandom);
        bus.d1_valid = 1'($urandom);
        bus.d2_valid = 1'($urandom);
    endtask

    // Returns one cycle after the load edge (first offer cycle), #1 past the edge
    task automatic do_load(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [2:0] m);
        @(posedge clk);
        #1;
        bus.d0       = a;
        bus.d1       = b;
        bus.d2       = c;
        bus.d0_valid = m[0];
        bus.d1_valid = m[1];
        bus.d2_valid = m[2];
        bus.load     = 1'b1;
        if (m[0]) exp_q.push_back('{is_done: 1'b0, b: a});
        if (m[1]) exp_q.push_back('{is_done: 1'b0, b: b});
        if (m[2]) exp_q.push_back('{is_done: 1'b0, b: c});
        exp_q.push_back('{is_done: 1'b1, b: 8'h00});
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        scramble();
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now({name, "_idle_timeout"});
    endtask

    task automatic check_busy(input string name, input int expv);
        @(posedge clk);
        #1;
        chk({name, "_busy_len"}, 32'(last_busy), 32'(expv));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load  = 1'b0;
        bus.ready = 1'b1;
        bus.d0 = '0; bus.d1 = '0; bus.d2 = '0;
        bus.d0_valid = 1'b0; bus.d1_valid = 1'b0; bus.d2_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_value", 32'(bus.value), 32'd0);
        chk("reset_put", 32'(bus.putFlag), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);

        // Full burst: 11,22,33 then done; busy 3+1
        do_load(8'h11, 8'h22, 8'h33, 3'b111);
        wait_idle("full");
        check_busy("full", 4);

        // Sparse mask 101: A5 then 5A back to back; busy 2+1
        do_load(8'hA5, 8'h77, 8'h5A, 3'b101);
        wait_idle("sparse");
        check_busy("sparse", 3);

        // Empty mask: done in the cycle after the load edge, no transfer
        do_load(8'h12, 8'h34, 8'h56, 3'b000);
        @(negedge clk);
        chk("empty_done", 32'(bus.done), 32'd1);
        chk("empty_put", 32'(bus.putFlag), 32'd0);
        wait_idle("empty");
        check_busy("empty", 1);

        // Stall two cycles while 22 is offered; busy 3+2+1
        do_load(8'h11, 8'h22, 8'h33, 3'b111);
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_offer_value", 32'(bus.value), 32'h22);
        chk("stall_offer_put", 32'(bus.putFlag), 32'd1);
        @(posedge clk);
        #1;
        bus.ready = 1'b1;
        wait_idle("stall");
        check_busy("stall", 6);

        // Loads during SEND and during the last GAP cycle are ignored
        do_load(8'h41, 8'h42, 8'h43, 3'b111);
        @(posedge clk);
        #1;
        bus.d0 = 8'hFF; bus.d1 = 8'hEE; bus.d2 = 8'hDD;
        bus.d0_valid = 1'b1; bus.d1_valid = 1'b1; bus.d2_valid = 1'b1;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        @(posedge clk);
        #1;
        chk("gap_done_when_load", 32'(bus.done), 32'd1);
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        @(negedge clk);
        chk("ignored_load_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ignored_load_no_put", 32'(bus.putFlag), 32'd0);
        end
        chk("ignored_load_busy_len", 32'(last_busy), 32'd4);

        // Reset right after the first transfer: outputs clear at once, no done
        do_load(8'hA1, 8'hB2, 8'hC3, 3'b111);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_value", 32'(bus.value), 32'd0);
        chk("midreset_put", 32'(bus.putFlag), 32'd0);
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk("midreset_done", 32'(bus.done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 32'(bus.busy), 32'd0);

        // Fresh burst after reset, mask 011
        do_load(8'hC4, 8'h4C, 8'h99, 3'b011);
        wait_idle("after_reset");
        check_busy("after_reset", 3);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
